motoro3_mos_deadtime: RTL
=========================

Name: motoro3_mos_deadtime

Overview:
Downstream stage of the 3-phase step-to-MOS decode. Consumes per-phase enable/polarity pairs (aE/aH1_L0, bE/bH1_L0, cE/cH1_L0) and produces six registered gate drives (high/low side per phase). Guarantees a programmable dead time whenever a phase leaves a driving state, so a phase's high and low gates are never both on. Latches a fault on illegal commutation patterns and forces all gates off until the fault is cleared.

Parameters:
DEAD_CYC, 20, dead time in clk cycles (2 us at 10 MHz); legal range 1..255
CW, 8, dead-time counter width; must satisfy 2^CW > DEAD_CYC

Ports:
clk       input   1   system clock, 10 MHz
rst       input   1   synchronous reset, active-high
aE        input   1   phase A drive enable
aH1_L0    input   1   phase A polarity: 1 = high side, 0 = low side (valid when aE=1)
bE        input   1   phase B drive enable
bH1_L0    input   1   phase B polarity
cE        input   1   phase C drive enable
cH1_L0    input   1   phase C polarity
faultClr  input   1   fault clear request, level
aHg       output  1   phase A high-side gate
aLg       output  1   phase A low-side gate
bHg       output  1   phase B high-side gate
bLg       output  1   phase B low-side gate
cHg       output  1   phase C high-side gate
cLg       output  1   phase C low-side gate
dtBusy    output  1   1 while any phase is in DEAD
fault     output  1   sticky illegal-pattern flag

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All logic updates on the rising edge of clk.
- Reset: all phase FSMs go to OFF with counters 0. All gate outputs, dtBusy and fault are 0 on the first edge with rst=1.
- Input stage: the six inputs are registered once. Per-phase request: OFF if E=0, HI if E=1 and H1_L0=1, LO if E=1 and H1_L0=0.
- Per-phase FSM states: OFF, HI, LO, DEAD. Gates are registered.
  - xHg = 1 only in HI; xLg = 1 only in LO; both are 0 in OFF and DEAD.
- OFF: request HI goes to HI and request LO goes to LO, with no dead time.
- HI or LO: a differing request (OFF or the opposite side) goes to DEAD and loads the counter with DEAD_CYC-1.
- DEAD: the counter decrements each cycle. When the counter is 0:
  - request HI goes to HI; request LO goes to LO; request OFF goes to OFF.
  - Exactly DEAD_CYC cycles have both gates low.
- Request changes during DEAD do not restart the counter. Only the request sampled at expiry matters, including a return to the previous side.
- Latency from an input change to the gate output change is 2 clk.
  - OFF->HI: xHg rises 2 cycles after the input change.
  - HI->LO: xHg falls after 2 cycles; xLg rises after 2+DEAD_CYC cycles.
- dtBusy is the combinational OR of (state==DEAD) over the three phases.
- Fault detection uses the registered requests. An illegal pattern is more than one phase requesting HI, or more than one phase requesting LO.
  - An illegal pattern sets fault on the next edge.
  - While fault=1, every phase currently in HI or LO goes to DEAD. Phases already in DEAD keep counting; at expiry they go to OFF and are held in OFF.
- Fault clear: fault clears when faultClr=1 and the registered pattern is legal on the same cycle. If faultClr=1 and the pattern is illegal, fault stays 1 (set wins).
  - After the clear, phases leave OFF normally on the following cycles.
- rst asserted mid-dead-time aborts the dead time immediately; all gates are 0. Driving requests applied after rst deasserts take the OFF->drive path with no dead time.

Optional Feature:
MOTORO3_DT_PWM_EN
- Defined:
  - Adds input pwmDuty[7:0] and an internal 8-bit free-running counter pwmCnt (reset 0, wraps 255->0).
  - The high-side gate output is (state==HI) && (pwmCnt < pwmDuty), registered.
  - Duty 0 keeps the high side off; duty 255 gives 255/256 on-time.
  - Low side is never chopped. PWM gating does not trigger dead time.
- Undefined: the pwmDuty port is absent and high gates follow state HI directly.

Test Plan:
- Reset, then aE=1,aH1_L0=1, bE=1,bH1_L0=0, cE=0 -> aHg=1 and bLg=1 two cycles later; all other gates 0; dtBusy=0.
- From aHg=1, set aH1_L0=0 with DEAD_CYC=20 -> aHg=0 at +2; aLg stays 0 for exactly 20 cycles and rises at +22; dtBusy=1 for those 20 cycles.
- Phase A HI->LO, then back to HI 5 cycles into DEAD -> aHg returns at +22; aLg never asserts; the counter is not restarted.
- aE=bE=1 with both H1_L0=1 -> fault=1 at +2; all gates low after their dead time expires. faultClr=1 with the pattern still illegal -> fault stays 1. Restore a legal pattern with faultClr=1 -> fault=0 on the next edge.
- rst pulsed 1 cycle during phase B DEAD -> all outputs 0 at that edge; bLg driving request asserts 2 cycles after rst deasserts with no dead time.
- With MOTORO3_DT_PWM_EN and pwmDuty=64 while phase A is HI -> aHg is high 64 of every 256 cycles; aLg stays 0.

Source files
------------

// File: rtl/motoro3_mos_deadtime.sv
// rtl/motoro3_mos_deadtime.sv - 3-phase MOS gate driver with dead-time insertion and illegal-pattern fault latch.
// Optional MOTORO3_DT_PWM_EN adds pwmDuty high-side chopping.
module motoro3_mos_deadtime #(
  parameter int DEAD_CYC = 20,
  parameter int CW       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       aE,
  input  logic       aH1_L0,
  input  logic       bE,
  input  logic       bH1_L0,
  input  logic       cE,
  input  logic       cH1_L0,
  input  logic       faultClr,
`ifdef MOTORO3_DT_PWM_EN
  input  logic [7:0] pwmDuty,
`endif
  output logic       aHg,
  output logic       aLg,
  output logic       bHg,
  output logic       bLg,
  output logic       cHg,
  output logic       cLg,
  output logic       dtBusy,
  output logic       fault
);

  typedef enum logic [1:0] {S_OFF, S_HI, S_LO, S_DEAD} state_t;

  localparam logic [CW-1:0] DEAD_LOAD = CW'(DEAD_CYC - 1);

  logic [2:0] en_q;
  logic [2:0] pol_q;
  logic [2:0] want_hi;
  logic [2:0] want_lo;
  logic [2:0] hg_q;
  logic [2:0] lg_q;
  logic [2:0] dead;
  logic       illegal;
  logic       hi_ok;

  function automatic logic multi(input logic [2:0] v);
    return (v & (v - 3'd1)) != 3'd0;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q  <= '0;
      pol_q <= '0;
    end else begin
      en_q  <= {cE, bE, aE};
      pol_q <= {cH1_L0, bH1_L0, aH1_L0};
    end
  end

  assign want_hi = en_q & pol_q;
  assign want_lo = en_q & ~pol_q;
  assign illegal = multi(want_hi) | multi(want_lo);

  // Set has priority over clear so an illegal pattern can never be cleared away.
  always_ff @(posedge clk) begin
    if (rst)           fault <= 1'b0;
    else if (illegal)  fault <= 1'b1;
    else if (faultClr) fault <= 1'b0;
  end

`ifdef MOTORO3_DT_PWM_EN
  logic [7:0] pwm_cnt;
  always_ff @(posedge clk) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + 8'd1;
  end
  assign hi_ok = pwm_cnt < pwmDuty;
`else
  assign hi_ok = 1'b1;
`endif

  for (genvar i = 0; i < 3; i++) begin : g_phase
    state_t        st;
    state_t        st_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;

    always_comb begin
      st_n  = st;
      cnt_n = cnt;
      case (st)
        S_OFF: begin
          if (!fault) begin
            if (want_hi[i])      st_n = S_HI;
            else if (want_lo[i]) st_n = S_LO;
          end
        end
        S_HI: begin
          if (fault || !want_hi[i]) begin
            st_n  = S_DEAD;
            cnt_n = DEAD_LOAD;
          end
        end
        S_LO: begin
          if (fault || !want_lo[i]) begin
            st_n  = S_DEAD;
            cnt_n = DEAD_LOAD;
          end
        end
        S_DEAD: begin
          // Only the request present at expiry decides the exit; changes mid-dead are ignored.
          if (cnt == '0) begin
            if (fault)           st_n = S_OFF;
            else if (want_hi[i]) st_n = S_HI;
            else if (want_lo[i]) st_n = S_LO;
            else                 st_n = S_OFF;
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
        default: st_n = S_OFF;
      endcase
    end

    // Gates are registered from the next state so they land on the same edge as the state.
    always_ff @(posedge clk) begin
      if (rst) begin
        st      <= S_OFF;
        cnt     <= '0;
        hg_q[i] <= 1'b0;
        lg_q[i] <= 1'b0;
      end else begin
        st      <= st_n;
        cnt     <= cnt_n;
        hg_q[i] <= (st_n == S_HI) && hi_ok;
        lg_q[i] <= (st_n == S_LO);
      end
    end

    assign dead[i] = (st == S_DEAD);
  end

  assign {cHg, bHg, aHg} = hg_q;
  assign {cLg, bLg, aLg} = lg_q;
  assign dtBusy = |dead;

endmodule
